// File: rtl/tipi_pkg.sv
// Shared encodings for the emulated Raspberry Pi side of the TIPI serial register link.
package tipi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD_H,
        ST_LOAD_L,
        ST_SHIFT_H,
        ST_SHIFT_L,
        ST_LATCH_H,
        ST_LATCH_L,
        ST_DONE
    } tipi_state_e;

    localparam logic RT_PI   = 1'b0;
    localparam logic RT_TI   = 1'b1;
    localparam logic CD_CTRL = 1'b0;
    localparam logic CD_DATA = 1'b1;

    localparam logic [2:0] BIT_TOP = 3'd7;

endpackage

// File: rtl/tipi_clkdiv.sv
// Half-period tick generator: pulses tick once every CLK_DIV clk_sys cycles, no backpressure.
// Synchronous clear reloads the count so the first half-period after clear is a full CLK_DIV long.
module tipi_clkdiv #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - 8'd1;
        if (clear || (cnt_q == 8'd0)) begin
            cnt_d = RELOAD;
        end
    end

    assign tick = ~clear & (cnt_q == 8'd0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tipi_rpi_link.sv
// Drives tipi_top's r_* pins to read TD/TC or write RD/RC one byte per request; 19*CLK_DIV+1 cycles
// from accept to rsp_valid; req_ready only in IDLE, requests while busy are ignored (host holds).
module tipi_rpi_link
    import tipi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tipi_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_cd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_status,
    output logic       busy,
    output logic       r_clk,
    output logic       r_cd,
    output logic       r_dout,
    output logic       r_le,
    output logic       r_rt,
    input  logic       r_din
);

    tipi_state_e state_q, state_d;
    logic        write_q, write_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_status_q, rsp_status_d;
    logic        r_clk_q, r_clk_d;
    logic        r_cd_q, r_cd_d;
    logic        r_dout_q, r_dout_d;
    logic        r_le_q, r_le_d;
    logic        r_rt_q, r_rt_d;
    logic        tick;

    tipi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (state_q == ST_IDLE),
        .tick    (tick)
    );

    assign req_ready  = (state_q == ST_IDLE) & ~tipi_reset;
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign r_clk      = r_clk_q;
    assign r_cd       = r_cd_q;
    assign r_dout     = r_dout_q;
    assign r_le       = r_le_q;
    assign r_rt       = r_rt_q;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        r_clk_d      = r_clk_q;
        r_cd_d       = r_cd_q;
        r_dout_d     = r_dout_q;
        r_le_d       = r_le_q;
        r_rt_d       = r_rt_q;

        case (state_q)
            ST_IDLE: begin
                r_clk_d = 1'b0;
                r_le_d  = 1'b0;
                if (req_valid && req_ready) begin
                    write_d      = req_write;
                    sh_d         = req_data;
                    bit_cnt_d    = BIT_TOP;
                    rsp_status_d = 1'b0;
                    r_rt_d       = req_write ? RT_PI : RT_TI;
                    r_cd_d       = req_cd ? CD_DATA : CD_CTRL;
                    r_dout_d     = req_write & req_data[7];
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: if (tick) begin
                r_clk_d = 1'b1;
                r_le_d  = ~write_q;
                state_d = write_q ? ST_SHIFT_H : ST_LOAD_H;
            end
            ST_LOAD_H: if (tick) begin
                r_clk_d = 1'b0;
                r_le_d  = 1'b0;
                state_d = ST_LOAD_L;
            end
            ST_LOAD_L: if (tick) begin
                r_clk_d = 1'b1;
                state_d = ST_SHIFT_H;
            end
            ST_SHIFT_H: if (tick) begin
                r_clk_d = 1'b0;
                state_d = ST_SHIFT_L;
                // Writes rotate so the byte is intact again after eight bits and can be echoed.
                if (write_q) begin
                    r_dout_d = sh_q[6];
                    sh_d     = {sh_q[6:0], sh_q[7]};
                end else begin
                    sh_d     = {sh_q[6:0], r_din};
                end
            end
            ST_SHIFT_L: if (tick) begin
                bit_cnt_d = bit_cnt_q - 3'd1;
                r_clk_d   = 1'b1;
                if (bit_cnt_q != 3'd0) begin
                    state_d = ST_SHIFT_H;
                end else if (write_q) begin
                    r_le_d  = 1'b1;
                    state_d = ST_LATCH_H;
                end else begin
                    r_clk_d    = 1'b0;
                    rsp_data_d = sh_q;
                    state_d    = ST_DONE;
                end
            end
            ST_LATCH_H: if (tick) begin
                r_clk_d      = 1'b0;
                rsp_status_d = r_din;
                state_d      = ST_LATCH_L;
            end
            ST_LATCH_L: if (tick) begin
                r_le_d     = 1'b0;
                rsp_data_d = sh_q;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                r_clk_d = 1'b0;
                r_le_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The TI holding the Pi in reset abandons any transfer without a response.
        if (tipi_reset) begin
            state_d = ST_IDLE;
            r_clk_d = 1'b0;
            r_le_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            sh_q         <= 8'd0;
            bit_cnt_q    <= 3'd0;
            rsp_data_q   <= 8'd0;
            rsp_status_q <= 1'b0;
            r_clk_q      <= 1'b0;
            r_cd_q       <= 1'b0;
            r_dout_q     <= 1'b0;
            r_le_q       <= 1'b0;
            r_rt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            r_clk_q      <= r_clk_d;
            r_cd_q       <= r_cd_d;
            r_dout_q     <= r_dout_d;
            r_le_q       <= r_le_d;
            r_rt_q       <= r_rt_d;
        end
    end

endmodule
